// File: rtl/multi_channel_trace_buffer.sv
// Multi-channel trace buffer: NUM_CH channels per sample in one shared circular memory.
// Trace mode captures a pre/post-trigger window; stream mode behaves as a FIFO.
module multi_channel_trace_buffer #(
  parameter int TRACE_WIDTH = 32,
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic                          CFG_VALID_I,
  output logic                          CFG_READY_O,
  input  logic                          CFG_MODE_I,
  input  logic [NUM_CH-1:0]             CFG_CH_MASK_I,
  input  logic [ADDR_WIDTH-1:0]         CFG_DELAY_I,
  input  logic                          ABORT_I,
  input  logic                          TRACE_VALID_I,
  input  logic [NUM_CH*TRACE_WIDTH-1:0] TRACE_I,
  input  logic                          TRIG_I,
  output logic                          TRIG_O,
  output logic                          DATA_VALID_O,
  input  logic                          DATA_READY_I,
  output logic [TRACE_WIDTH-1:0]        DATA_O,
  output logic [CH_WIDTH-1:0]           DATA_CH_O,
  output logic                          DATA_LAST_O,
  output logic [2:0]                    STAT_STATE_O,
  output logic [ADDR_WIDTH-1:0]         STAT_TRIG_PTR_O,
  output logic                          STAT_OVERFLOW_O
);

  localparam int SAMPLE_W = NUM_CH * TRACE_WIDTH;
  localparam int CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_READOUT = 3'd3,
    S_STREAM  = 3'd4
  } state_t;

  function automatic logic [CH_WIDTH-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    first_ch = {CH_WIDTH{1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      first_ch = mask[k] ? CH_WIDTH'(k) : first_ch;
    end
  endfunction

  function automatic logic [CH_WIDTH-1:0] next_ch(input logic [NUM_CH-1:0] mask,
                                                  input logic [CH_WIDTH-1:0] ch);
    next_ch = ch;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      next_ch = (mask[k] && (k > int'(ch))) ? CH_WIDTH'(k) : next_ch;
    end
  endfunction

  function automatic logic is_last_ch(input logic [NUM_CH-1:0] mask,
                                      input logic [CH_WIDTH-1:0] ch);
    is_last_ch = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      is_last_ch = (mask[k] && (k > int'(ch))) ? 1'b0 : is_last_ch;
    end
  endfunction

  logic [SAMPLE_W-1:0]    r_mem [DEPTH];
  logic [SAMPLE_W-1:0]    r_mem_q;

  state_t                 r_state;
  logic                   r_cfg_ready;
  logic [NUM_CH-1:0]      r_mask;
  logic [ADDR_WIDTH-1:0]  r_delay;
  logic [ADDR_WIDTH-1:0]  r_wptr;
  logic [CNT_W-1:0]       r_count;
  logic [ADDR_WIDTH-1:0]  r_remain;
  logic [ADDR_WIDTH-1:0]  r_trig_ptr;
  logic                   r_overflow;
  logic                   r_trig;
  logic [ADDR_WIDTH-1:0]  r_raddr;
  logic [CNT_W-1:0]       r_rrem;
  logic [CNT_W-1:0]       r_issued;
  logic [CH_WIDTH-1:0]    r_rch;
  logic                   r_s1_valid;
  logic [CH_WIDTH-1:0]    r_s1_ch;
  logic                   r_s1_last;
  logic                   r_s1_pop;
  logic                   r_dvalid;
  logic [TRACE_WIDTH-1:0] r_data;
  logic [CH_WIDTH-1:0]    r_dch;
  logic                   r_dlast;
  logic                   r_dpop;

  state_t                 w_state_nxt;
  logic                   w_cfg_acc;
  logic [NUM_CH-1:0]      w_cfg_mask;
  logic                   w_out_free;
  logic                   w_out_acc;
  logic                   w_pop;
  logic                   w_s1_free;
  logic                   w_gen_avail;
  logic                   w_issue;
  logic                   w_last_ch;
  logic [CH_WIDTH-1:0]    w_first_ch;
  logic                   w_full;
  logic                   w_wr_en;
  logic                   w_drop;
  logic                   w_trig_hit;
  logic                   w_enter_ro;
  logic [ADDR_WIDTH-1:0]  w_wptr_nxt;
  logic [CNT_W-1:0]       w_count_nxt;
  logic [CNT_W-1:0]       w_issued_nxt;
  logic [ADDR_WIDTH-1:0]  w_start_addr;

  assign w_cfg_acc    = CFG_VALID_I && r_cfg_ready && !ABORT_I;
  assign w_cfg_mask   = (CFG_CH_MASK_I == {NUM_CH{1'b0}}) ? {NUM_CH{1'b1}} : CFG_CH_MASK_I;
  assign w_out_free   = !r_dvalid || DATA_READY_I;
  assign w_out_acc    = r_dvalid && DATA_READY_I;
  assign w_pop        = w_out_acc && r_dpop && (r_state == S_STREAM);
  assign w_s1_free    = !r_s1_valid || w_out_free;
  assign w_issue      = w_gen_avail && w_s1_free && !ABORT_I;
  assign w_last_ch    = is_last_ch(r_mask, r_rch);
  assign w_first_ch   = first_ch(r_mask);
  assign w_full       = (r_count == FULL_CNT);
  assign w_trig_hit   = (r_state == S_ARMED) && TRACE_VALID_I && TRIG_I && !ABORT_I;
  assign w_enter_ro   = (r_state != S_READOUT) && (w_state_nxt == S_READOUT);
  assign w_wptr_nxt   = w_wr_en ? (r_wptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) : r_wptr;
  assign w_start_addr = (w_count_nxt == FULL_CNT) ? w_wptr_nxt : {ADDR_WIDTH{1'b0}};

  // Next-state selection; abort overrides every other event.
  always_comb begin
    w_state_nxt = r_state;
    if (ABORT_I) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CFG_VALID_I) w_state_nxt = CFG_MODE_I ? S_STREAM : S_ARMED;
          else             w_state_nxt = S_IDLE;
        end
        S_ARMED: begin
          if (w_trig_hit) w_state_nxt = (r_delay == {ADDR_WIDTH{1'b0}}) ? S_READOUT : S_POST;
          else            w_state_nxt = S_ARMED;
        end
        S_POST: begin
          if (TRACE_VALID_I && (r_remain == {{(ADDR_WIDTH-1){1'b0}}, 1'b1})) w_state_nxt = S_READOUT;
          else                                                               w_state_nxt = S_POST;
        end
        S_READOUT: begin
          if (w_out_acc && r_dlast) w_state_nxt = S_IDLE;
          else                      w_state_nxt = S_READOUT;
        end
        S_STREAM: w_state_nxt = S_STREAM;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Write enable, drop detection and read-generator availability.
  always_comb begin
    w_wr_en     = 1'b0;
    w_drop      = 1'b0;
    w_gen_avail = 1'b0;
    case (r_state)
      S_ARMED, S_POST: w_wr_en = TRACE_VALID_I && !ABORT_I;
      S_READOUT:       w_gen_avail = (r_rrem != {CNT_W{1'b0}});
      S_STREAM: begin
        w_wr_en     = TRACE_VALID_I && !ABORT_I && (!w_full || w_pop);
        w_drop      = TRACE_VALID_I && !ABORT_I && w_full && !w_pop;
        w_gen_avail = (r_count > r_issued);
      end
      default: w_wr_en = 1'b0;
    endcase
  end

  // Occupancy (stream) or saturating sample count (trace), plus samples issued ahead of pop.
  always_comb begin
    w_count_nxt  = r_count;
    w_issued_nxt = r_issued;
    if (r_state == S_STREAM) begin
      case ({w_wr_en, w_pop})
        2'b10:   w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   w_count_nxt = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: w_count_nxt = r_count;
      endcase
      case ({w_issue && w_last_ch, w_pop})
        2'b10:   w_issued_nxt = r_issued + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   w_issued_nxt = r_issued - {{(CNT_W-1){1'b0}}, 1'b1};
        default: w_issued_nxt = r_issued;
      endcase
    end else if (w_wr_en && !w_full) begin
      w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Sample storage and registered read port; not reset.
  always_ff @(posedge CLK_I) begin
    if (w_wr_en) r_mem[r_wptr] <= TRACE_I;
    if (w_issue) r_mem_q <= r_mem[r_raddr];
  end

  // Control state, pointers, counters and status flags.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state     <= S_IDLE;
      r_cfg_ready <= 1'b1;
      r_mask      <= {NUM_CH{1'b0}};
      r_delay     <= {ADDR_WIDTH{1'b0}};
      r_wptr      <= {ADDR_WIDTH{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_remain    <= {ADDR_WIDTH{1'b0}};
      r_trig_ptr  <= {ADDR_WIDTH{1'b0}};
      r_overflow  <= 1'b0;
      r_trig      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == S_IDLE);
      r_trig      <= w_enter_ro;
      if (w_cfg_acc) begin
        r_mask     <= w_cfg_mask;
        r_delay    <= CFG_DELAY_I;
        r_wptr     <= {ADDR_WIDTH{1'b0}};
        r_count    <= {CNT_W{1'b0}};
        r_overflow <= 1'b0;
      end else begin
        r_wptr     <= w_wptr_nxt;
        r_count    <= w_count_nxt;
        r_overflow <= r_overflow || w_drop;
      end
      if (w_trig_hit) begin
        r_trig_ptr <= r_wptr;
        r_remain   <= r_delay;
      end else if ((r_state == S_POST) && TRACE_VALID_I && !ABORT_I) begin
        r_remain   <= r_remain - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_remain   <= r_remain;
      end
    end
  end

  // Read generator: walks samples and enabled channels, one word issued per cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_raddr  <= {ADDR_WIDTH{1'b0}};
      r_rrem   <= {CNT_W{1'b0}};
      r_issued <= {CNT_W{1'b0}};
      r_rch    <= {CH_WIDTH{1'b0}};
    end else begin
      r_issued <= w_cfg_acc ? {CNT_W{1'b0}} : w_issued_nxt;
      if (w_enter_ro) begin
        r_raddr <= w_start_addr;
        r_rrem  <= w_count_nxt;
        r_rch   <= w_first_ch;
      end else if (w_cfg_acc) begin
        r_raddr <= {ADDR_WIDTH{1'b0}};
        r_rrem  <= {CNT_W{1'b0}};
        r_rch   <= first_ch(w_cfg_mask);
      end else if (w_issue && w_last_ch) begin
        r_raddr <= r_raddr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        r_rch   <= w_first_ch;
        r_rrem  <= (r_state == S_READOUT) ? (r_rrem - {{(CNT_W-1){1'b0}}, 1'b1}) : r_rrem;
      end else if (w_issue) begin
        r_rch   <= next_ch(r_mask, r_rch);
      end else begin
        r_rch   <= r_rch;
      end
    end
  end

  // Two-stage readout pipeline (memory read, then output register) with backpressure.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= {CH_WIDTH{1'b0}};
      r_s1_last  <= 1'b0;
      r_s1_pop   <= 1'b0;
      r_dvalid   <= 1'b0;
      r_data     <= {TRACE_WIDTH{1'b0}};
      r_dch      <= {CH_WIDTH{1'b0}};
      r_dlast    <= 1'b0;
      r_dpop     <= 1'b0;
    end else if (ABORT_I || ((r_state == S_READOUT) && w_out_acc && r_dlast)) begin
      r_s1_valid <= 1'b0;
      r_dvalid   <= 1'b0;
      r_dlast    <= 1'b0;
    end else begin
      if (w_s1_free) begin
        r_s1_valid <= w_issue;
        r_s1_ch    <= r_rch;
        r_s1_last  <= (r_state == S_READOUT) && (r_rrem == {{(CNT_W-1){1'b0}}, 1'b1}) && w_last_ch;
        r_s1_pop   <= w_last_ch;
      end
      if (w_out_free && r_s1_valid) begin
        r_dvalid <= 1'b1;
        r_data   <= r_mem_q[int'(r_s1_ch)*TRACE_WIDTH +: TRACE_WIDTH];
        r_dch    <= r_s1_ch;
        r_dlast  <= r_s1_last;
        r_dpop   <= r_s1_pop;
      end else if (w_out_free) begin
        r_dvalid <= 1'b0;
        r_dlast  <= 1'b0;
      end
    end
  end

  assign CFG_READY_O     = r_cfg_ready;
  assign TRIG_O          = r_trig;
  assign DATA_VALID_O    = r_dvalid;
  assign DATA_O          = r_data;
  assign DATA_CH_O       = r_dch;
  assign DATA_LAST_O     = r_dlast;
  assign STAT_STATE_O    = r_state;
  assign STAT_TRIG_PTR_O = r_trig_ptr;
  assign STAT_OVERFLOW_O = r_overflow;

endmodule

// File: tb/tb_multi_channel_trace_buffer.sv
// Directed bench for multi_channel_trace_buffer: trace windows, wrap, backpressure, stream, abort, reset.
module tb_multi_channel_trace_buffer;

  localparam int TW  = 16;
  localparam int NCH = 4;
  localparam int DEP = 16;

  logic            CLK_I = 1'b0;
  logic            RST_I;
  logic            CFG_VALID_I;
  logic            CFG_READY_O;
  logic            CFG_MODE_I;
  logic [NCH-1:0]  CFG_CH_MASK_I;
  logic [3:0]      CFG_DELAY_I;
  logic            ABORT_I;
  logic            TRACE_VALID_I;
  logic [NCH*TW-1:0] TRACE_I;
  logic            TRIG_I;
  logic            TRIG_O;
  logic            DATA_VALID_O;
  logic            DATA_READY_I;
  logic [TW-1:0]   DATA_O;
  logic [1:0]      DATA_CH_O;
  logic            DATA_LAST_O;
  logic [2:0]      STAT_STATE_O;
  logic [3:0]      STAT_TRIG_PTR_O;
  logic            STAT_OVERFLOW_O;

  int total = 0;
  int bad   = 0;

  multi_channel_trace_buffer #(.TRACE_WIDTH(TW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .CFG_VALID_I(CFG_VALID_I), .CFG_READY_O(CFG_READY_O), .CFG_MODE_I(CFG_MODE_I),
    .CFG_CH_MASK_I(CFG_CH_MASK_I), .CFG_DELAY_I(CFG_DELAY_I), .ABORT_I(ABORT_I),
    .TRACE_VALID_I(TRACE_VALID_I), .TRACE_I(TRACE_I), .TRIG_I(TRIG_I), .TRIG_O(TRIG_O),
    .DATA_VALID_O(DATA_VALID_O), .DATA_READY_I(DATA_READY_I), .DATA_O(DATA_O),
    .DATA_CH_O(DATA_CH_O), .DATA_LAST_O(DATA_LAST_O), .STAT_STATE_O(STAT_STATE_O),
    .STAT_TRIG_PTR_O(STAT_TRIG_PTR_O), .STAT_OVERFLOW_O(STAT_OVERFLOW_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_I);
  endtask

  // Channel k of sample s carries k*256 + s.
  function automatic logic [NCH*TW-1:0] make_sample(input int s);
    logic [NCH*TW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*TW +: TW] = 16'(k*256 + s);
    return v;
  endfunction

  task automatic do_cfg(input logic mode, input logic [3:0] mask, input logic [3:0] delay);
    CFG_VALID_I = 1'b1; CFG_MODE_I = mode; CFG_CH_MASK_I = mask; CFG_DELAY_I = delay;
    tick();
    CFG_VALID_I = 1'b0;
  endtask

  task automatic drive(input int s, input logic trig);
    TRACE_VALID_I = 1'b1; TRACE_I = make_sample(s); TRIG_I = trig;
    tick();
  endtask

  task automatic idle_in();
    TRACE_VALID_I = 1'b0; TRIG_I = 1'b0;
  endtask

  // Every valid cycle must present the next expected word; a stalled word stays put.
  task automatic drain(input string tag, input int first_s, input int nsamp,
                       input logic [3:0] mask, input bit toggle, input bit trace_mode);
    logic [31:0] exp_q[$];
    int got;
    int cyc;
    for (int s = 0; s < nsamp; s++)
      for (int k = 0; k < NCH; k++)
        if (mask[k]) exp_q.push_back({13'd0, 16'(k*256 + first_s + s), 2'(k), 1'b0});
    exp_q[exp_q.size()-1][0] = trace_mode;
    got = 0;
    cyc = 0;
    while (got < exp_q.size() && cyc < 1000) begin
      DATA_READY_I = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (DATA_VALID_O) begin
        check(tag, {13'd0, DATA_O, DATA_CH_O, DATA_LAST_O}, exp_q[got]);
        if (DATA_READY_I) got++;
      end
      cyc++;
      tick();
    end
    check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
    DATA_READY_I = 1'b0;
  endtask

  initial begin
    RST_I = 1'b1; CFG_VALID_I = 1'b0; CFG_MODE_I = 1'b0; CFG_CH_MASK_I = 4'h0;
    CFG_DELAY_I = 4'h0; ABORT_I = 1'b0; TRACE_VALID_I = 1'b0; TRACE_I = '0;
    TRIG_I = 1'b0; DATA_READY_I = 1'b0;
    #12;
    check("rst_state", 32'(STAT_STATE_O), 32'd0);
    check("rst_cfg_ready", 32'(CFG_READY_O), 32'd1);
    check("rst_valid", 32'(DATA_VALID_O), 32'd0);
    tick();
    RST_I = 1'b0;
    tick();

    // Window: trigger on 10, delay 3, mask 0101.
    do_cfg(1'b0, 4'b0101, 4'd3);
    check("t1_armed", 32'(STAT_STATE_O), 32'd1);
    check("t1_cfg_ready", 32'(CFG_READY_O), 32'd0);
    for (int s = 0; s < 20; s++) begin
      drive(s, s == 10);
      if (s == 12) check("t1_post", 32'(STAT_STATE_O), 32'd2);
      if (s == 12) check("t1_trig_early", 32'(TRIG_O), 32'd0);
      if (s == 13) check("t1_trig", 32'(TRIG_O), 32'd1);
      if (s == 13) check("t1_readout", 32'(STAT_STATE_O), 32'd3);
      if (s == 14) check("t1_trig_pulse", 32'(TRIG_O), 32'd0);
      if (s == 14) check("t1_valid_lat1", 32'(DATA_VALID_O), 32'd0);
      if (s == 15) check("t1_valid_lat2", 32'(DATA_VALID_O), 32'd1);
    end
    idle_in();
    check("t1_trig_ptr", 32'(STAT_TRIG_PTR_O), 32'd10);
    drain("t1_word", 0, 14, 4'b0101, 1'b0, 1'b1);
    check("t1_idle", 32'(STAT_STATE_O), 32'd0);
    check("t1_done_valid", 32'(DATA_VALID_O), 32'd0);
    check("t1_done_ready", 32'(CFG_READY_O), 32'd1);

    // Wrap: trigger on 25, delay 3.
    do_cfg(1'b0, 4'b0101, 4'd3);
    for (int s = 0; s < 30; s++) begin
      drive(s, s == 25);
      if (s == 28) check("t2_trig", 32'(TRIG_O), 32'd1);
    end
    idle_in();
    check("t2_trig_ptr", 32'(STAT_TRIG_PTR_O), 32'd9);
    drain("t2_word", 13, 16, 4'b0101, 1'b0, 1'b1);
    check("t2_idle", 32'(STAT_STATE_O), 32'd0);

    // Delay 0, trigger on 5, toggling ready.
    do_cfg(1'b0, 4'b0101, 4'd0);
    for (int s = 0; s < 6; s++) drive(s, s == 5);
    idle_in();
    check("t3_readout", 32'(STAT_STATE_O), 32'd3);
    check("t3_trig", 32'(TRIG_O), 32'd1);
    check("t3_trig_ptr", 32'(STAT_TRIG_PTR_O), 32'd5);
    drain("t3_word", 0, 6, 4'b0101, 1'b1, 1'b1);
    check("t3_idle", 32'(STAT_STATE_O), 32'd0);

    // Stream: zero mask means all channels, overflow after 16 samples.
    do_cfg(1'b1, 4'b0000, 4'd0);
    check("t4_stream", 32'(STAT_STATE_O), 32'd4);
    for (int s = 0; s < 20; s++) begin
      drive(s, 1'b0);
      if (s == 1)  check("t4_valid_lat1", 32'(DATA_VALID_O), 32'd0);
      if (s == 2)  check("t4_valid_lat2", 32'(DATA_VALID_O), 32'd1);
      if (s == 15) check("t4_no_ovf", 32'(STAT_OVERFLOW_O), 32'd0);
      if (s == 16) check("t4_ovf", 32'(STAT_OVERFLOW_O), 32'd1);
    end
    idle_in();
    drain("t4_word", 0, 16, 4'b1111, 1'b0, 1'b0);
    tick();
    check("t4_empty", 32'(DATA_VALID_O), 32'd0);
    check("t4_still_stream", 32'(STAT_STATE_O), 32'd4);

    // Aborts: from stream, from POST, mid-READOUT.
    ABORT_I = 1'b1; tick(); ABORT_I = 1'b0;
    check("t5_abort_idle", 32'(STAT_STATE_O), 32'd0);
    check("t5_ovf_kept", 32'(STAT_OVERFLOW_O), 32'd1);
    do_cfg(1'b0, 4'b0101, 4'd5);
    check("t5_ovf_clear", 32'(STAT_OVERFLOW_O), 32'd0);
    for (int s = 0; s < 3; s++) drive(s, s == 1);
    idle_in();
    check("t5_post", 32'(STAT_STATE_O), 32'd2);
    ABORT_I = 1'b1; tick(); ABORT_I = 1'b0;
    check("t5_post_abort", 32'(STAT_STATE_O), 32'd0);
    check("t5_post_ready", 32'(CFG_READY_O), 32'd1);
    do_cfg(1'b0, 4'b0101, 4'd0);
    for (int s = 0; s < 4; s++) drive(s, s == 3);
    idle_in();
    DATA_READY_I = 1'b1;
    tick(); tick();
    check("t5_first_word", {13'd0, DATA_O, DATA_CH_O, DATA_LAST_O}, 32'h0);
    tick();
    check("t5_mid_valid", 32'(DATA_VALID_O), 32'd1);
    ABORT_I = 1'b1; tick(); ABORT_I = 1'b0;
    DATA_READY_I = 1'b0;
    check("t5_ro_abort", 32'(STAT_STATE_O), 32'd0);
    check("t5_ro_valid", 32'(DATA_VALID_O), 32'd0);
    check("t5_ro_ready", 32'(CFG_READY_O), 32'd1);

    // Asynchronous reset in the middle of stream mode.
    do_cfg(1'b1, 4'b1111, 4'd0);
    for (int s = 0; s < 3; s++) drive(s, 1'b0);
    idle_in();
    tick();
    check("t6_stream_valid", 32'(DATA_VALID_O), 32'd1);
    #2 RST_I = 1'b1;
    #1;
    check("t6_rst_state", 32'(STAT_STATE_O), 32'd0);
    check("t6_rst_ready", 32'(CFG_READY_O), 32'd1);
    check("t6_rst_valid", 32'(DATA_VALID_O), 32'd0);
    check("t6_rst_data", 32'(DATA_O), 32'd0);
    tick();
    RST_I = 1'b0;
    tick();
    check("t6_after_rst", 32'(STAT_STATE_O), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
